// File: rtl/eflash_enc_pkg.sv
// Shared types for the eFlash thermometer output encoder: FSM states, capture mode, helpers.
package eflash_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        ENCODE,
        OUTPUT
    } state_e;

    typedef logic mode_t;

    localparam mode_t MODE_RBR      = 1'b0;
    localparam mode_t MODE_PARALLEL = 1'b1;

    function automatic int unsigned ipow(input int unsigned base, input int unsigned exp);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < exp; i++) begin
            r = r * base;
        end
        return r;
    endfunction

endpackage

// File: rtl/eflash_therm_count.sv
// Counts leading ones of one MSB-aligned thermometer sample and flags whether it is a legal code.
module eflash_therm_count #(
    parameter  int THERM_W = 8,
    localparam int CNT_W   = $clog2(THERM_W + 1)
) (
    input  logic [THERM_W-1:0] code_i,
    output logic [CNT_W-1:0]   count_o,
    output logic               valid_o
);

    logic run;

    always_comb begin
        count_o = '0;
        run     = 1'b1;
        for (int i = THERM_W - 1; i >= 0; i--) begin
            if (run && code_i[i]) begin
                count_o = count_o + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // A legal code is exactly count_o ones followed by zeros.
    assign valid_o = (code_i == ~({THERM_W{1'b1}} >> count_o));

endmodule

// File: rtl/eflash_out_encoder_seq.sv
// Sequenced eFlash thermometer encoder: captures 1 (rbr) or NUM_CH (parallel) samples, encodes base THERM_W+1.
// Optional invalid-code checking with sticky err_o is enabled by defining EFLASH_ENC_ERR_CHK_EN.
module eflash_out_encoder_seq
    import eflash_enc_pkg::*;
#(
    parameter  int THERM_W = 8,
    parameter  int NUM_CH  = 2,
    localparam int OUT_W   = $clog2(ipow(THERM_W + 1, NUM_CH))
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mode_i,
    input  logic               start_i,
    input  logic               sample_valid_i,
    input  logic [THERM_W-1:0] sample_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [OUT_W-1:0]   out_data_o,
    output logic               busy_o,
    input  logic               err_clr_i,
    output logic               err_o
);

    localparam int CNT_W = $clog2(THERM_W + 1);
    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam int RADIX = THERM_W + 1;

    state_e             state_q, state_d;
    mode_t              mode_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_target;
    logic [THERM_W-1:0] slot_q [NUM_CH];
    logic [CNT_W-1:0]   cnt    [NUM_CH];
    logic [CNT_W-1:0]   digit  [NUM_CH];
    logic [NUM_CH-1:0]  code_ok;
    logic [OUT_W-1:0]   res_d, res_p1;
    logic               done, take, hs, seq_start;

    assign idx_target = (mode_q == MODE_PARALLEL) ? IDX_W'(NUM_CH) : IDX_W'(1);
    assign done       = (idx_q == idx_target);
    assign take       = (state_q == CAPTURE) && sample_valid_i && !done;
    assign hs         = (state_q == OUTPUT) && out_ready_i;
    assign seq_start  = start_i && ((state_q == IDLE) || hs);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        eflash_therm_count #(.THERM_W(THERM_W)) u_cnt (
            .code_i  (slot_q[g]),
            .count_o (cnt[g]),
            .valid_o (code_ok[g])
        );
`ifdef EFLASH_ENC_ERR_CHK_EN
        assign digit[g] = code_ok[g] ? cnt[g] : '0;
`else
        assign digit[g] = cnt[g];
`endif
    end

    // Horner evaluation keeps slot0 as the most significant base-(THERM_W+1) digit.
    always_comb begin
        res_d = '0;
        if (mode_q == MODE_PARALLEL) begin
            for (int k = 0; k < NUM_CH; k++) begin
                res_d = OUT_W'(res_d * RADIX) + OUT_W'(digit[k]);
            end
        end else begin
            res_d = OUT_W'(digit[0]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = CAPTURE;
            CAPTURE: if (done) state_d = ENCODE;
            ENCODE:  state_d = OUTPUT;
            OUTPUT:  if (out_ready_i) state_d = start_i ? CAPTURE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // capture stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= MODE_RBR;
            idx_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                slot_q[k] <= '0;
            end
        end else if (seq_start) begin
            mode_q <= mode_i;
            idx_q  <= '0;
        end else if (take) begin
            idx_q <= idx_q + IDX_W'(1);
            for (int k = 0; k < NUM_CH; k++) begin
                if (idx_q == IDX_W'(k)) slot_q[k] <= sample_i;
            end
        end
    end

    // encode stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_p1 <= '0;
        end else if (state_q == ENCODE) begin
            res_p1 <= res_d;
        end
    end

    assign out_valid_o = (state_q == OUTPUT);
    assign out_data_o  = out_valid_o ? res_p1 : '0;
    assign busy_o      = (state_q != IDLE);

`ifdef EFLASH_ENC_ERR_CHK_EN
    logic bad_code;
    assign bad_code = (mode_q == MODE_PARALLEL) ? !(&code_ok) : !code_ok[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end else if ((state_q == ENCODE) && bad_code) begin
            err_o <= 1'b1;
        end
    end
`else
    logic [NUM_CH:0] unused_err_chk;
    assign unused_err_chk = {err_clr_i, code_ok};
    assign err_o          = 1'b0;
`endif

endmodule
